// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the data-memory req/gnt/rvalid handshake and loads the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds mem_misalign and traps unaligned word accesses).
module mem_stage_ctrl #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_valid,
  input  logic [XLEN-1:0]    mem_alu_res,
  input  logic [XLEN-1:0]    mem_rs2o,
  input  logic               mem_memwr,
  input  logic [1:0]         mem_wbsel,
  input  logic [XLEN-1:0]    mem_pcp4,
  input  logic [RADDR_W-1:0] mem_rdaddr,
  output logic               mem_stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               wb_valid,
  output logic               wb_regwr,
  output logic [RADDR_W-1:0] wb_rdaddr,
  output logic [XLEN-1:0]    wb_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic               mem_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  localparam logic [XLEN-1:0] ADDR_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_regwr_q, wb_regwr_d;
  logic [RADDR_W-1:0] wb_rdaddr_q, wb_rdaddr_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               misalign_q, misalign_d;
  logic               is_access_s;
  logic               misaligned_s;

  // Next-state, handshake and writeback decode
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    wb_regwr_d  = 1'b0;
    wb_rdaddr_d = wb_rdaddr_q;
    wb_data_d   = wb_data_q;
    rd_d        = rd_q;
    misalign_d  = 1'b0;
    mem_stall   = 1'b0;
    is_access_s = mem_valid & (mem_memwr | (mem_wbsel == 2'b01));
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned_s = (mem_alu_res[1:0] != 2'b00);
`else
    misaligned_s = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (is_access_s && misaligned_s) begin
          // Trap: no memory request, retire as a non-writing bubble-free slot
          misalign_d  = 1'b1;
          wb_valid_d  = 1'b1;
          wb_regwr_d  = 1'b0;
          wb_rdaddr_d = mem_rdaddr;
        end else if (is_access_s) begin
          mem_stall = 1'b1;
          req_d     = 1'b1;
          we_d      = mem_memwr;
          addr_d    = mem_alu_res & ADDR_MASK;
          wdata_d   = mem_rs2o;
          rd_d      = mem_rdaddr;
          state_d   = REQ;
        end else if (mem_valid) begin
          wb_valid_d  = 1'b1;
          wb_rdaddr_d = mem_rdaddr;
          wb_data_d   = (mem_wbsel == 2'b10) ? mem_pcp4 : mem_alu_res;
          wb_regwr_d  = (mem_rdaddr != {RADDR_W{1'b0}});
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem_gnt && req_q && we_q) begin
          mem_stall   = 1'b0;
          req_d       = 1'b0;
          wb_valid_d  = 1'b1;
          wb_regwr_d  = 1'b0;
          wb_rdaddr_d = rd_q;
          state_d     = IDLE;
        end else if (dmem_gnt && req_q) begin
          req_d   = 1'b0;
          state_d = RSP;
        end else begin
          req_d = req_q;
        end
      end
      RSP: begin
        mem_stall = 1'b1;
        if (dmem_rvalid) begin
          mem_stall   = 1'b0;
          wb_valid_d  = 1'b1;
          wb_data_d   = dmem_rdata;
          wb_rdaddr_d = rd_q;
          wb_regwr_d  = (rd_q != {RADDR_W{1'b0}});
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {XLEN{1'b0}};
      wdata_q     <= {XLEN{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_regwr_q  <= 1'b0;
      wb_rdaddr_q <= {RADDR_W{1'b0}};
      wb_data_q   <= {XLEN{1'b0}};
      rd_q        <= {RADDR_W{1'b0}};
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_regwr_q  <= wb_regwr_d;
      wb_rdaddr_q <= wb_rdaddr_d;
      wb_data_q   <= wb_data_d;
      rd_q        <= rd_d;
      misalign_q  <= misalign_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_regwr   = wb_regwr_q;
  assign wb_rdaddr  = wb_rdaddr_q;
  assign wb_data    = wb_data_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mem_misalign = misalign_q;
`else
  logic unused_misalign_s;
  assign unused_misalign_s = misalign_q ^ misaligned_s;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected writebacks, a monitor pops them on wb_valid.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_rs2o;
  logic        mem_memwr;
  logic [1:0]  mem_wbsel;
  logic [31:0] mem_pcp4;
  logic [4:0]  mem_rdaddr;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_regwr;
  logic [4:0]  wb_rdaddr;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  mem_stage_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_alu_res(mem_alu_res), .mem_rs2o(mem_rs2o),
    .mem_memwr(mem_memwr), .mem_wbsel(mem_wbsel), .mem_pcp4(mem_pcp4),
    .mem_rdaddr(mem_rdaddr), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_rdaddr(wb_rdaddr), .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .mem_misalign(mem_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        regwr;
    logic        chk_data;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic rw, input logic cd);
    exp_t e;
    e.rd = rd; e.data = d; e.regwr = rw; e.chk_data = cd; e.at = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic op(input logic v, input logic wr, input logic [1:0] sel, input logic [31:0] alu,
                    input logic [31:0] rs2, input logic [31:0] pc, input logic [4:0] rd);
    mem_valid = v; mem_memwr = wr; mem_wbsel = sel; mem_alu_res = alu;
    mem_rs2o = rs2; mem_pcp4 = pc; mem_rdaddr = rd;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  // Monitor: every writeback must match the head of the scoreboard, in the expected cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h required no writeback (cycle %0d)",
                 wb_rdaddr, wb_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (wb_regwr !== mon_e.regwr || cyc != mon_e.at ||
            (mon_e.chk_data && (wb_data !== mon_e.data || wb_rdaddr !== mon_e.rd))) begin
          n_fail++;
          $display("FAIL wb: got cyc=%0d rd=%0d data=0x%08h regwr=%0b required cyc=%0d rd=%0d data=0x%08h regwr=%0b",
                   cyc, wb_rdaddr, wb_data, wb_regwr, mon_e.at, mon_e.rd, mon_e.data, mon_e.regwr);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    #2;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_regwr", {31'd0, wb_regwr}, 32'd0);
    chk("rst_wb_rdaddr", {27'd0, wb_rdaddr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("rst_misalign", {31'd0, mem_misalign}, 32'd0);
`endif
    next(); next();
    rst_n = 1'b1;

    // Non-memory ops: ALU, rd=0, JAL, reserved select
    op(1'b1, 1'b0, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd5); push(5'd5, 32'h1234, 1'b1, 1'b1);
    samp(); chk("alu_stall", {31'd0, mem_stall}, 32'd0); next();
    op(1'b1, 1'b0, 2'b00, 32'h55, 32'h0, 32'h0, 5'd0); push(5'd0, 32'h55, 1'b0, 1'b1);
    samp(); chk("alu_rd0_stall", {31'd0, mem_stall}, 32'd0); next();
    op(1'b1, 1'b0, 2'b10, 32'h999, 32'h0, 32'h44, 5'd1); push(5'd1, 32'h44, 1'b1, 1'b1);
    samp(); chk("jal_stall", {31'd0, mem_stall}, 32'd0); next();
    op(1'b1, 1'b0, 2'b11, 32'h77, 32'h0, 32'h88, 5'd3); push(5'd3, 32'h77, 1'b1, 1'b1);
    samp(); chk("rsv_stall", {31'd0, mem_stall}, 32'd0); next();
    idle();
    samp(); chk("bubble_stall", {31'd0, mem_stall}, 32'd0); next();

    // Store with grant delayed three REQ cycles
    op(1'b1, 1'b1, 2'b00, 32'h100, 32'hDEADBEEF, 32'h0, 5'd9);
    samp(); chk("st_idle_stall", {31'd0, mem_stall}, 32'd1); chk("st_idle_req", {31'd0, dmem_req}, 32'd0); next();
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("st_wait_req", {31'd0, dmem_req}, 32'd1);
      chk("st_wait_we", {31'd0, dmem_we}, 32'd1);
      chk("st_wait_addr", dmem_addr, 32'h100);
      chk("st_wait_wdata", dmem_wdata, 32'hDEADBEEF);
      chk("st_wait_stall", {31'd0, mem_stall}, 32'd1);
      next();
    end
    dmem_gnt = 1'b1; push(5'd9, 32'h0, 1'b0, 1'b0);
    samp(); chk("st_gnt_stall", {31'd0, mem_stall}, 32'd0); chk("st_gnt_req", {31'd0, dmem_req}, 32'd1); next();
    dmem_gnt = 1'b0; idle();
    samp(); chk("st_done_req", {31'd0, dmem_req}, 32'd0); next();

    // Load (gnt first REQ cycle, rvalid two cycles later) followed by a JAL
    op(1'b1, 1'b0, 2'b01, 32'h200, 32'h0, 32'h0, 5'd7);
    samp(); chk("ld_idle_stall", {31'd0, mem_stall}, 32'd1); next();
    dmem_gnt = 1'b1;
    samp();
    chk("ld_req", {31'd0, dmem_req}, 32'd1); chk("ld_we", {31'd0, dmem_we}, 32'd0);
    chk("ld_addr", dmem_addr, 32'h200); chk("ld_req_stall", {31'd0, mem_stall}, 32'd1);
    next();
    dmem_gnt = 1'b0;
    samp(); chk("ld_rsp_req", {31'd0, dmem_req}, 32'd0); chk("ld_rsp_stall", {31'd0, mem_stall}, 32'd1); next();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D; push(5'd7, 32'hCAFEF00D, 1'b1, 1'b1);
    samp(); chk("ld_rv_stall", {31'd0, mem_stall}, 32'd0); next();
    dmem_rvalid = 1'b0;
    op(1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h44, 5'd1); push(5'd1, 32'h44, 1'b1, 1'b1);
    samp(); chk("b2b_jal_stall", {31'd0, mem_stall}, 32'd0); next();

    // Load to rd=0; rvalid coinciding with gnt must be ignored
    op(1'b1, 1'b0, 2'b01, 32'h300, 32'h0, 32'h0, 5'd0);
    samp(); next();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h00000BAD;
    samp(); chk("ld2_gnt_rv_stall", {31'd0, mem_stall}, 32'd1); next();
    dmem_gnt = 1'b0; dmem_rdata = 32'h1111; push(5'd0, 32'h1111, 1'b0, 1'b1);
    samp(); chk("ld2_rv_stall", {31'd0, mem_stall}, 32'd0); next();
    dmem_rvalid = 1'b0; idle();
    samp(); next();

    // Misaligned load
`ifdef MEM_MISALIGN_TRAP_EN
    op(1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 32'h0, 5'd4); push(5'd4, 32'h0, 1'b0, 1'b0);
    samp(); chk("mis_stall", {31'd0, mem_stall}, 32'd0); next();
    idle();
    samp(); chk("mis_flag", {31'd0, mem_misalign}, 32'd1); chk("mis_req", {31'd0, dmem_req}, 32'd0); next();
    samp(); chk("mis_flag_clr", {31'd0, mem_misalign}, 32'd0); next();
`else
    op(1'b1, 1'b0, 2'b01, 32'h202, 32'h0, 32'h0, 5'd4);
    samp(); chk("mis_stall", {31'd0, mem_stall}, 32'd1); next();
    dmem_gnt = 1'b1;
    samp(); chk("mis_addr", dmem_addr, 32'h200); chk("mis_req", {31'd0, dmem_req}, 32'd1); next();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD; push(5'd4, 32'hABCD, 1'b1, 1'b1);
    samp(); chk("mis_rv_stall", {31'd0, mem_stall}, 32'd0); next();
    dmem_rvalid = 1'b0; idle();
    samp(); next();
`endif

    // Reset while a load waits in RSP; a stray rvalid afterwards is ignored
    op(1'b1, 1'b0, 2'b01, 32'h400, 32'h0, 32'h0, 5'd6);
    samp(); next();
    dmem_gnt = 1'b1;
    samp(); next();
    dmem_gnt = 1'b0;
    samp(); chk("rr_rsp_stall", {31'd0, mem_stall}, 32'd1);
    #1; rst_n = 1'b0; idle();
    #1;
    chk("rr_req", {31'd0, dmem_req}, 32'd0);
    chk("rr_wb_valid", {31'd0, wb_valid}, 32'd0);
    next();
    rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555;
    samp(); chk("rr_stray_stall", {31'd0, mem_stall}, 32'd0); next();
    samp(); chk("rr_stray_wb", {31'd0, wb_valid}, 32'd0); next();
    dmem_rvalid = 1'b0;
    next(); next();

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register: takes the mem_* bundle, runs the data-memory access over a req/gnt/rvalid handshake, and loads the MEM/WB register.
- Holds the EX/MEM register through mem_stall while an access is outstanding.
- Non-memory instructions pass to writeback with a fixed 1-cycle latency.
- Word-only accesses.

Parameters:
- XLEN, 32, datapath/address width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- mem_alu_res  in  XLEN  ALU result; memory address for loads/stores.
- mem_rs2o  in  XLEN  store data.
- mem_memwr  in  1  store.
- mem_wbsel  in  2  writeback select: 00 ALU, 01 load data (marks a load), 10 PC+4, 11 reserved (treated as ALU).
- mem_pcp4  in  XLEN  PC+4.
- mem_rdaddr  in  RADDR_W  destination register.
- mem_stall  out  1  combinational; upstream holds EX/MEM while 1.
- dmem_req  out  1  registered request.
- dmem_we  out  1  registered write enable.
- dmem_addr  out  XLEN  registered address.
- dmem_wdata  out  XLEN  registered write data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load data.
- wb_valid  out  1  MEM/WB slot valid.
- wb_regwr  out  1  register-file write enable.
- wb_rdaddr  out  RADDR_W  destination register.
- wb_data  out  XLEN  writeback value, already muxed.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_regwr, wb_rdaddr and wb_data all go to 0 immediately.
- Access definition: access = mem_valid & (mem_memwr | mem_wbsel==01). If both mem_memwr and wbsel==01 are set, it is a store.
- State IDLE:
  - Bubble (mem_valid=0): wb_valid<=0, wb_regwr<=0.
  - Non-access: next edge wb_valid<=1, wb_rdaddr<=mem_rdaddr, wb_data<=(wbsel==10 ? mem_pcp4 : mem_alu_res), wb_regwr<=(mem_rdaddr!=0). mem_stall=0.
  - Access: mem_stall=1. Next edge: dmem_req<=1, dmem_we<=mem_memwr, dmem_addr<=mem_alu_res, dmem_wdata<=mem_rs2o, latch rdaddr, state<=REQ, wb_valid<=0.
- State REQ:
  - dmem_req held with stable addr/data until dmem_gnt.
  - Without gnt: mem_stall=1.
  - gnt & store: mem_stall=0 this cycle. Next edge: dmem_req<=0, wb_valid<=1, wb_regwr<=0, state<=IDLE.
  - gnt & load: mem_stall=1. Next edge: dmem_req<=0, state<=RSP.
- State RSP:
  - Without dmem_rvalid: mem_stall=1.
  - rvalid: mem_stall=0 this cycle. Next edge: wb_valid<=1, wb_data<=dmem_rdata, wb_regwr<=(latched rdaddr!=0), state<=IDLE.
- wb_valid=0 in every cycle the stage is stalled (a bubble is inserted into WB).
- Latency:
  - Non-memory op: 1 cycle.
  - Store: 2 cycles minimum (gnt in the first REQ cycle).
  - Load: 3 cycles minimum (gnt, then rvalid the following cycle).
- Handshake rules:
  - dmem_rvalid is ignored outside RSP.
  - dmem_rvalid in the same cycle as gnt is not legal from the memory side and is ignored.
  - dmem_gnt is ignored when dmem_req=0.
- Mid-operation reset: dmem_req drops immediately; any response arriving after reset release is ignored (state IDLE).
- Inputs are sampled only in IDLE. While stalled, mem_* must be held by upstream, but the stage uses latched copies, so changes on mem_* are harmless.
- Back-to-back: an access may start in the IDLE cycle immediately after completion.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port mem_misalign (1 bit, registered, reset 0).
  - An access in IDLE with mem_alu_res[1:0]!=0 issues no dmem request and gives mem_stall=0.
  - Next edge: mem_misalign<=1 for one cycle, wb_valid<=1, wb_regwr<=0.
- Undefined:
  - No port.
  - dmem_addr[1:0] is forced to 00 and the access proceeds normally.

Test Plan:
- Reset mid-load: assert rst_n=0 while in RSP -> dmem_req=0 and wb_valid=0 immediately. After release, a stray dmem_rvalid produces no wb_valid.
- ALU op: mem_valid=1, wbsel=00, alu_res=0x1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_regwr=1, mem_stall never 1. Same with rd=0 -> wb_regwr=0.
- Store: memwr=1, addr=0x100, rs2o=0xDEADBEEF, gnt delayed 3 cycles -> dmem_req held 3 cycles with we=1 and stable addr/data, mem_stall=1 throughout. Stall drops in the gnt cycle; wb_valid=1 with wb_regwr=0 the next cycle.
- Load: wbsel=01, addr=0x200, rd=7; gnt in the first REQ cycle, rvalid 2 cycles later with rdata=0xCAFEF00D -> wb_data=0xCAFEF00D, wb_rdaddr=7, wb_regwr=1 one cycle after rvalid. wb_valid=0 in all earlier cycles.
- Back-to-back: load followed by a JAL (wbsel=10, pcp4=0x44) -> the JAL writes back 0x44 exactly one cycle after the load's writeback.
- With MEM_MISALIGN_TRAP_EN: load at addr 0x202 -> dmem_req never asserted; next cycle mem_misalign=1, wb_valid=1, wb_regwr=0. Without the macro: dmem_addr=0x200.
